basys3_gpio: RTL and testbench

// AXI4-Lite slave exposing Basys 3 board I/O to a processor: 16 LEDs, 16 switches,
// 4-digit seven-segment display (SSD) and 4 push buttons (L/U/R/D) with press counters.

---
 rtl/basys3_gpio.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_basys3_gpio.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/basys3_gpio.sv
// basys3_gpio: AXI4-Lite register block for the Basys 3 board I/O.
// Provides LEDs, switches, a multiplexed 4-digit seven-segment display and
// four push buttons, each with a 32-bit press counter. Single clock domain.
// All pin inputs pass through two-flop synchronisers.

module basys3_gpio #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int REFRESH_BITS       = 17
) (
    input  logic                              s_axi_aclk,
    input  logic                              s_axi_aresetn,
    // write address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [2:0]                        s_axi_awprot,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    // write response channel
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    // read address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [2:0]                        s_axi_arprot,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    // read data channel
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    // board pins
    input  logic [15:0]                       sw,
    input  logic                              btnL,
    input  logic                              btnU,
    input  logic                              btnR,
    input  logic                              btnD,
    output logic [15:0]                       led,
    output logic [3:0]                        an,
    output logic [6:0]                        seg
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // word indices taken from addr[5:2]
    localparam logic [3:0] IDX_CONFIG  = 4'd0;
    localparam logic [3:0] IDX_LED     = 4'd1;
    localparam logic [3:0] IDX_SW      = 4'd2;
    localparam logic [3:0] IDX_SSD     = 4'd3;
    localparam logic [3:0] IDX_BTN_ALL = 4'd4;
    localparam logic [3:0] IDX_BTNL    = 4'd5;
    localparam logic [3:0] IDX_LAST    = 4'd8;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                    axi_live_reg;   // low during reset and the cycle leaving it
    logic                    aw_held_reg;
    logic [3:0]              aw_idx_reg;
    logic                    w_held_reg;
    logic [15:0]             wdata_reg;
    logic [1:0]              wstrb_reg;
    logic                    bvalid_reg;
    logic [1:0]              bresp_reg;
    logic                    rvalid_reg;
    logic [31:0]             rdata_reg;
    logic [1:0]              rresp_reg;

    logic                    ssd_en_reg;
    logic [15:0]             led_reg;
    logic [15:0]             ssd_reg;

    logic [15:0]             sw_meta_reg;
    logic [15:0]             sw_sync_reg;
    logic [3:0]              btn_meta_reg;
    logic [3:0]              btn_sync_reg;
    logic [3:0]              btn_prev_reg;
    logic [31:0]             btn_cnt_reg [4];

    logic [REFRESH_BITS-1:0] refresh_reg;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        aw_fire;
    logic        w_fire;
    logic        ar_fire;
    logic        wr_go;
    logic [3:0]  btn_raw;
    logic [3:0]  btn_press;
    logic [31:0] rd_data_next;
    logic [1:0]  rd_resp_next;
    logic [1:0]  digit;
    logic [3:0]  nibble;

    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0],
                           s_axi_araddr[1:0], s_axi_wdata[31:16], s_axi_wstrb[3:2]};

    assign s_axi_awready = axi_live_reg & ~aw_held_reg & ~bvalid_reg;
    assign s_axi_wready  = axi_live_reg & ~w_held_reg & ~bvalid_reg;
    assign s_axi_arready = axi_live_reg & ~rvalid_reg;

    assign aw_fire = s_axi_awvalid & s_axi_awready;
    assign w_fire  = s_axi_wvalid & s_axi_wready;
    assign ar_fire = s_axi_arvalid & s_axi_arready;
    // both halves of a write are held: commit this cycle
    assign wr_go   = aw_held_reg & w_held_reg;

    assign s_axi_bvalid = bvalid_reg;
    assign s_axi_bresp  = bresp_reg;
    assign s_axi_rvalid = rvalid_reg;
    assign s_axi_rdata  = rdata_reg;
    assign s_axi_rresp  = rresp_reg;

    assign led = led_reg;

    assign btn_raw   = {btnD, btnR, btnU, btnL};
    assign btn_press = btn_sync_reg & ~btn_prev_reg;

    // Active-low hex font, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] lit;
        case (value)
            4'h0: lit = 7'h3F;
            4'h1: lit = 7'h06;
            4'h2: lit = 7'h5B;
            4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66;
            4'h5: lit = 7'h6D;
            4'h6: lit = 7'h7D;
            4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F;
            4'h9: lit = 7'h6F;
            4'hA: lit = 7'h77;
            4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39;
            4'hD: lit = 7'h5E;
            4'hE: lit = 7'h79;
            default: lit = 7'h71;
        endcase
        return ~lit;
    endfunction

    // ------------------------------------------------------------------
    // Write channel: latch AW and W independently, commit once both held
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            axi_live_reg <= 1'b0;
            aw_held_reg  <= 1'b0;
            aw_idx_reg   <= '0;
            w_held_reg   <= 1'b0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
        end else begin
            axi_live_reg <= 1'b1;
            if (aw_fire) begin
                aw_held_reg <= 1'b1;
                aw_idx_reg  <= s_axi_awaddr[5:2];
            end
            if (w_fire) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= s_axi_wdata[15:0];
                wstrb_reg  <= s_axi_wstrb[1:0];
            end
            if (wr_go) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= (aw_idx_reg <= IDX_LAST) ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_reg && s_axi_bready) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    // Writable control registers with per-byte enables
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            ssd_en_reg <= 1'b1;
            led_reg    <= '0;
            ssd_reg    <= '0;
        end else if (wr_go) begin
            if (aw_idx_reg == IDX_CONFIG && wstrb_reg[0]) begin
                ssd_en_reg <= wdata_reg[0];
            end
            for (int b = 0; b < 2; b++) begin
                if (aw_idx_reg == IDX_LED && wstrb_reg[b]) begin
                    led_reg[b*8 +: 8] <= wdata_reg[b*8 +: 8];
                end
                if (aw_idx_reg == IDX_SSD && wstrb_reg[b]) begin
                    ssd_reg[b*8 +: 8] <= wdata_reg[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel: register data one cycle after the address handshake
    // ------------------------------------------------------------------
    // Read decode of the presented address
    always_comb begin
        rd_data_next = '0;
        rd_resp_next = RESP_OKAY;
        case (s_axi_araddr[5:2])
            4'd0:    rd_data_next = {31'd0, ssd_en_reg};
            4'd1:    rd_data_next = {16'd0, led_reg};
            4'd2:    rd_data_next = {16'd0, sw_sync_reg};
            4'd3:    rd_data_next = {16'd0, ssd_reg};
            4'd4:    rd_data_next = {28'd0, btn_sync_reg};
            4'd5:    rd_data_next = btn_cnt_reg[0];
            4'd6:    rd_data_next = btn_cnt_reg[1];
            4'd7:    rd_data_next = btn_cnt_reg[2];
            4'd8:    rd_data_next = btn_cnt_reg[3];
            default: rd_resp_next = RESP_SLVERR;
        endcase
    end

    // Read response register, held until the master accepts it
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else if (ar_fire) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_data_next;
            rresp_reg  <= rd_resp_next;
        end else if (rvalid_reg && s_axi_rready) begin
            rvalid_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pin synchronisers and button edge history
    // ------------------------------------------------------------------
    // Two-flop synchronisers plus one extra stage for edge detection
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
            btn_meta_reg <= '0;
            btn_sync_reg <= '0;
            btn_prev_reg <= '0;
        end else begin
            sw_meta_reg  <= sw;
            sw_sync_reg  <= sw_meta_reg;
            btn_meta_reg <= btn_raw;
            btn_sync_reg <= btn_meta_reg;
            btn_prev_reg <= btn_sync_reg;
        end
    end

    // Press counters: a write to a counter's offset clears it and beats a press
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn_cnt
            localparam logic [3:0] CNT_IDX = 4'(IDX_BTNL + gi);
            logic clear;
            assign clear = wr_go && (aw_idx_reg == CNT_IDX);

            // Count rising edges of the synchronised button level
            always_ff @(posedge s_axi_aclk) begin
                if (!s_axi_aresetn) begin
                    btn_cnt_reg[gi] <= '0;
                end else if (clear) begin
                    btn_cnt_reg[gi] <= '0;
                end else if (btn_press[gi]) begin
                    btn_cnt_reg[gi] <= btn_cnt_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Seven-segment multiplexing
    // ------------------------------------------------------------------
    // Free-running refresh counter; its top two bits select the digit
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            refresh_reg <= '0;
        end else begin
            refresh_reg <= refresh_reg + 1'b1;
        end
    end

    assign digit  = refresh_reg[REFRESH_BITS-1 -: 2];
    assign nibble = ssd_reg[{digit, 2'b00} +: 4];

    // Drive the active anode low and decode its nibble, or blank everything
    always_comb begin
        an  = 4'hF;
        seg = 7'h7F;
        if (ssd_en_reg) begin
            an  = ~(4'b0001 << digit);
            seg = hex_to_seg(nibble);
        end
    end

endmodule

// File: tb/tb_basys3_gpio.sv
// tb_basys3_gpio: directed AXI4-Lite stimulus with a response scoreboard.
// Stimulus pushes expected responses; a negedge monitor pops and compares
// whenever bvalid or rvalid is presented.

module tb_basys3_gpio;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [5:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [5:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [15:0] sw;
    logic        btnL, btnU, btnR, btnD;
    logic [15:0] led;
    logic [3:0]  an;
    logic [6:0]  seg;

    always #5 clk = ~clk;

    basys3_gpio #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(6),
        .REFRESH_BITS(6)
    ) dut (
        .s_axi_aclk(clk),       .s_axi_aresetn(aresetn),
        .s_axi_awaddr(awaddr),  .s_axi_awprot(awprot),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata),    .s_axi_wstrb(wstrb),
        .s_axi_wvalid(wvalid),  .s_axi_wready(wready),
        .s_axi_bresp(bresp),    .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_araddr(araddr),  .s_axi_arprot(arprot),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata),    .s_axi_rresp(rresp),
        .s_axi_rvalid(rvalid),  .s_axi_rready(rready),
        .sw(sw), .btnL(btnL), .btnU(btnU), .btnR(btnR), .btnD(btnD),
        .led(led), .an(an), .seg(seg)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Monitor: pop and compare on every presented response
    always @(negedge clk) begin
        if (aresetn === 1'b1) begin
            if (bvalid) begin
                if (wr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_bvalid: got bresp=%0d want none", bresp);
                end else begin
                    mon_e = wr_q.pop_front();
                    $display("write %s bresp=%0d", mon_e.name, bresp);
                    check({mon_e.name, "_bresp"}, {30'd0, bresp}, {30'd0, mon_e.resp});
                end
            end
            if (rvalid) begin
                if (rd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rvalid: got rdata=%h want none", rdata);
                end else begin
                    mon_e = rd_q.pop_front();
                    $display("read %s rdata=%h rresp=%0d", mon_e.name, rdata, rresp);
                    check({mon_e.name, "_rdata"}, rdata, mon_e.data);
                    check({mon_e.name, "_rresp"}, {30'd0, rresp}, {30'd0, mon_e.resp});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait until the monitor has consumed every expected response
    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0) && cyc < 40) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d pending responses want 0", name, rd_q.size() + wr_q.size());
            rd_q.delete();
            wr_q.delete();
        end
    endtask

    // Write with W delayed by wdly cycles relative to AW
    task automatic axi_wr(input string name, input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] r, input int wdly);
        exp_t e;
        int   cyc;
        logic awf, wf, aw_done, w_done;
        e.name = name; e.data = 32'd0; e.resp = r;
        wr_q.push_back(e);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = (wdly == 0);
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            awf = awvalid & awready;
            wf  = wvalid & wready;
            @(posedge clk);
            #1;
            cyc++;
            if (awf) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (wf)  begin wvalid  = 1'b0; w_done  = 1'b1; end
            if (!w_done && cyc >= wdly) wvalid = 1'b1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            total++; bad++;
            $display("FAIL %s_handshake: got aw=%0b w=%0b want 1 1", name, aw_done, w_done);
        end
        drain(name);
    endtask

    task automatic axi_rd(input string name, input logic [5:0] a, input logic [31:0] d, input logic [1:0] r);
        exp_t e;
        int   cyc;
        logic fire;
        e.name = name; e.data = d; e.resp = r;
        rd_q.push_back(e);
        araddr = a; arvalid = 1'b1; cyc = 0; fire = 1'b0;
        while (!fire && cyc < 40) begin
            fire = arready;
            @(posedge clk);
            #1;
            cyc++;
        end
        arvalid = 1'b0;
        if (!fire) begin
            total++; bad++;
            $display("FAIL %s_arready: got 0 want 1", name);
        end
        drain(name);
    endtask

    // Wait for digit i to become active, then check its segments
    task automatic check_digit(input int i, input logic [6:0] seg_exp);
        logic [3:0] one;
        logic [3:0] an_exp;
        int         cyc;
        one = 4'b0001;
        an_exp = ~(one << i);
        cyc = 0;
        while (an !== an_exp && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        $display("ssd digit%0d an=%b seg=%h", i, an, seg);
        check($sformatf("an_digit%0d", i), {28'd0, an}, {28'd0, an_exp});
        check($sformatf("seg_digit%0d", i), {25'd0, seg}, {25'd0, seg_exp});
    endtask

    logic [6:0] seg_tab [4] = '{7'h12, 7'h40, 7'h79, 7'h00};   // digits 5,0,1,8

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        sw = '0; btnL = 1'b0; btnU = 1'b0; btnR = 1'b0; btnD = 1'b0;

        // Reset state
        tick(4);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready",  {31'd0, wready},  32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_led",     {16'd0, led},     32'd0);
        check("rst_an",      {28'd0, an},      32'hE);
        check("rst_seg",     {25'd0, seg},     32'h40);
        aresetn = 1'b1;
        tick(1);
        check("post_rst_awready", {31'd0, awready}, 32'd1);
        axi_rd("config_rst", 6'h00, 32'd1, OKAY);
        axi_rd("ssd_rst",    6'h0C, 32'd0, OKAY);

        // 1: switches
        sw = 16'hBABA;
        tick(4);
        axi_rd("sw", 6'h08, 32'h0000BABA, OKAY);

        // 2: AW and W together
        axi_wr("led_same", 6'h04, 32'h000012AA, 4'hF, OKAY, 0);
        check("led_12aa", {16'd0, led}, 32'h12AA);

        // 3: W one cycle after AW
        axi_wr("led_split", 6'h04, 32'h0000CECE, 4'hF, OKAY, 1);
        check("led_cece", {16'd0, led}, 32'hCECE);
        axi_rd("led_rb", 6'h04, 32'h0000CECE, OKAY);

        // 6b: byte strobe touches led[7:0] only
        axi_wr("led_strb", 6'h04, 32'hFFFF0055, 4'b0001, OKAY, 0);
        check("led_ce55", {16'd0, led}, 32'hCE55);

        // 4: button presses, clear, levels
        for (int p = 0; p < 7; p++) begin
            btnL = 1'b1; tick(4);
            btnL = 1'b0; tick(4);
        end
        tick(3);
        axi_rd("btnl_cnt7", 6'h14, 32'd7, OKAY);
        axi_wr("btnl_clr", 6'h14, 32'h12345678, 4'hF, OKAY, 0);
        axi_rd("btnl_cnt0", 6'h14, 32'd0, OKAY);
        btnU = 1'b1;
        tick(4);
        axi_rd("btn_all", 6'h10, 32'h00000002, OKAY);
        axi_rd("btnu_cnt1", 6'h18, 32'd1, OKAY);
        btnU = 1'b0;

        // Clear and press land on the same cycle: clear wins
        btnR = 1'b1; tick(4); btnR = 1'b0; tick(6);
        axi_rd("btnr_cnt1", 6'h1C, 32'd1, OKAY);
        btnR = 1'b1;
        tick(1);
        axi_wr("btnr_clr_race", 6'h1C, 32'd0, 4'hF, OKAY, 0);
        tick(3);
        axi_rd("btnr_race", 6'h1C, 32'd0, OKAY);
        btnR = 1'b0;
        tick(4);

        // 5: seven-segment display
        axi_wr("ssd", 6'h0C, 32'h00008105, 4'hF, OKAY, 0);
        for (int i = 0; i < 4; i++) check_digit(i, seg_tab[i]);
        axi_wr("config_off", 6'h00, 32'd0, 4'hF, OKAY, 0);
        check("an_off",  {28'd0, an},  32'hF);
        check("seg_off", {25'd0, seg}, 32'h7F);
        axi_rd("config_rb", 6'h00, 32'd0, OKAY);

        // 6: unmapped and read-only offsets
        axi_rd("unmapped_rd", 6'h24, 32'd0, SLVERR);
        axi_wr("unmapped_wr", 6'h24, 32'hFFFFFFFF, 4'hF, SLVERR, 0);
        axi_wr("ro_sw_wr",    6'h08, 32'h00001111, 4'hF, OKAY, 0);
        axi_rd("sw_after_wr", 6'h08, 32'h0000BABA, OKAY);
        axi_rd("led_after",   6'h04, 32'h0000CE55, OKAY);

        tick(4);
        check("queues_empty", rd_q.size() + wr_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
